// File: rtl/spart_brg_ctrl_if.sv
// spart_brg_ctrl_if: processor bus between the CPU and the SPART bus-side controller
interface spart_brg_ctrl_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  modport master (output iocs, iorw, ioaddr, wdata, input rdata);
  modport slave (input iocs, iorw, ioaddr, wdata, output rdata);
endinterface

// File: rtl/spart_brg_ctrl.sv
// spart_brg_ctrl: SPART bus decode, divisor assembly/load and one-byte TX buffer; define SPART_DIV_READBACK_EN for DB_LO/DB_HI readback
module spart_brg_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic                   clk,
  input  logic                   rst,
  spart_brg_ctrl_if.slave        bus,
  input  logic                   rda,
  input  logic [7:0]             rx_data,
  output logic                   rx_ack,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_load,
  output logic [15:0]            brg_in,
  output logic                   brg_wr_en,
  output logic                   cfg_busy
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, LO_PEND = 2'd2, LOAD = 2'd3;
  logic [1:0]  state, state_nxt;
  logic [7:0]  lo_stage, tx_buf, db_rd;
  logic        tbe, ovr;
  logic        wr, rd, wr_data, wr_lo, wr_hi, rd_stat, drain;
  logic [15:0] div_raw;
  assign wr      = bus.iocs & ~bus.iorw;
  assign rd      = bus.iocs & bus.iorw;
  assign wr_data = wr & (bus.ioaddr == 2'b00);
  assign wr_lo   = wr & (bus.ioaddr == 2'b10) & (state != BOOT);
  assign wr_hi   = wr & (bus.ioaddr == 2'b11) & (state != BOOT);
  assign rd_stat = rd & (bus.ioaddr == 2'b01);
  assign drain   = ~tbe & tx_ready;
  // a lone DB_HI write keeps the current low byte; a staged DB_LO replaces it
  assign div_raw   = {bus.wdata, (state == LO_PEND) ? lo_stage : brg_in[7:0]};
  assign brg_wr_en = ~rst & ((state == BOOT) | (state == LOAD));
  assign cfg_busy  = state != RUN;
  assign rx_ack    = rd & (bus.ioaddr == 2'b00);
`ifdef SPART_DIV_READBACK_EN
  assign db_rd = bus.ioaddr[0] ? brg_in[15:8] : brg_in[7:0];
`else
  assign db_rd = 8'h00;
`endif
  assign bus.rdata = ~rd ? 8'h00 :
                     (bus.ioaddr == 2'b00) ? rx_data :
                     (bus.ioaddr == 2'b01) ? {5'b0, ovr, tbe, rda} : db_rd;
  always_comb
    state_nxt = wr_hi ? LOAD : wr_lo ? LO_PEND : (state == LO_PEND) ? LO_PEND : RUN;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= BOOT;
      brg_in   <= DEFAULT_DIV;
      lo_stage <= 8'h00;
      tx_buf   <= 8'h00;
      tx_data  <= 8'h00;
      tx_load  <= 1'b0;
      tbe      <= 1'b1;
      ovr      <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_load <= drain;
      if (wr_lo) lo_stage <= bus.wdata;
      if (wr_hi) brg_in <= (div_raw == 16'd0) ? 16'd1 : div_raw;
      if (drain) tx_data <= tx_buf;
      if (wr_data & (tbe | drain)) tx_buf <= bus.wdata;
      tbe <= wr_data ? 1'b0 : (tbe | drain);
      ovr <= (wr_data & ~tbe & ~drain) | (ovr & ~rd_stat);
    end
endmodule

// File: tb/tb_spart_brg_ctrl.sv
// tb_spart_brg_ctrl: directed and randomized checks of spart_brg_ctrl against a queue-based model
module tb_spart_brg_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rda = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ack, tx_load, brg_wr_en, cfg_busy;
  logic [7:0]  tx_data;
  logic [15:0] brg_in;
  int          vectors = 0, miscompares = 0;
  spart_brg_ctrl_if bus();
  spart_brg_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .rda(rda), .rx_data(rx_data), .rx_ack(rx_ack),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_load(tx_load), .brg_in(brg_in),
    .brg_wr_en(brg_wr_en), .cfg_busy(cfg_busy)
  );
  always #5 clk = ~clk;
  // model: divisor register, staged low byte, TX buffer as a queue of at most one byte
  logic        started = 1'b0;
  logic        m_boot, m_pulse, m_lo_pend, m_ovr, m_tx_load, ovr_set, drain;
  logic [7:0]  m_lo, m_tx_data;
  logic [15:0] m_brg, md;
  logic [7:0]  q[$];
  always @(posedge clk)
    if (rst) begin
      started = 1'b1; m_boot = 1'b1; m_pulse = 1'b1; m_lo_pend = 1'b0; m_lo = 8'h00;
      m_brg = 16'd325; q.delete(); m_ovr = 1'b0; m_tx_load = 1'b0; m_tx_data = 8'h00;
    end else begin
      m_pulse = 1'b0;
      if (!m_boot && bus.iocs && !bus.iorw && bus.ioaddr == 2'd2) begin
        m_lo = bus.wdata; m_lo_pend = 1'b1;
      end
      if (!m_boot && bus.iocs && !bus.iorw && bus.ioaddr == 2'd3) begin
        md = {bus.wdata, m_lo_pend ? m_lo : m_brg[7:0]};
        m_brg = (md == 16'd0) ? 16'd1 : md;
        m_lo_pend = 1'b0; m_pulse = 1'b1;
      end
      m_boot = 1'b0;
      drain = (q.size() != 0) && tx_ready;
      m_tx_load = drain;
      if (drain) m_tx_data = q.pop_front();
      ovr_set = bus.iocs && !bus.iorw && bus.ioaddr == 2'd0 && q.size() != 0;
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'd0 && q.size() == 0) q.push_back(bus.wdata);
      m_ovr = ovr_set || (m_ovr && !(bus.iocs && bus.iorw && bus.ioaddr == 2'd1));
    end
  function automatic logic [7:0] exp_rdata();
    if (!(bus.iocs && bus.iorw)) return 8'h00;
    if (bus.ioaddr == 2'd0) return rx_data;
    if (bus.ioaddr == 2'd1) return {5'b0, m_ovr, q.size() == 0, rda};
`ifdef SPART_DIV_READBACK_EN
    return bus.ioaddr[0] ? m_brg[15:8] : m_brg[7:0];
`else
    return 8'h00;
`endif
  endfunction
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      chk("brg_in", brg_in, m_brg);
      chk("brg_wr_en", 16'(brg_wr_en), 16'(m_pulse && !rst));
      chk("cfg_busy", 16'(cfg_busy), 16'(m_pulse || m_lo_pend));
      chk("tx_load", 16'(tx_load), 16'(m_tx_load));
      chk("tx_data", 16'(tx_data), 16'(m_tx_data));
      chk("rdata", 16'(bus.rdata), 16'(exp_rdata()));
      chk("rx_ack", 16'(rx_ack), 16'(bus.iocs && bus.iorw && bus.ioaddr == 2'd0));
    end
  task automatic cyc(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    bus.iocs = cs; bus.iorw = rw; bus.ioaddr = a; bus.wdata = d;
  endtask
  initial begin
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'd0; bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("lit_boot_wr_en", 16'(brg_wr_en), 16'd1);
    chk("lit_boot_brg", brg_in, 16'd325);
    cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_boot_done", 16'({brg_wr_en, cfg_busy}), 16'd0);
    cyc(1, 0, 2, 8'h44); cyc(1, 0, 3, 8'h01); cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_div_0144", brg_in, 16'h0144);
    chk("lit_div_wr_en", 16'(brg_wr_en), 16'd1);
    chk("lit_model_0144", m_brg, 16'h0144);
    cyc(1, 0, 2, 8'h00); cyc(1, 0, 3, 8'h00); cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_div_zero", brg_in, 16'h0001);
    cyc(1, 0, 3, 8'h02); cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_div_lone_hi", brg_in, 16'h0201);
    cyc(1, 0, 0, 8'hA5); cyc(1, 0, 0, 8'h5A); cyc(1, 1, 1, 0); @(negedge clk);
    chk("lit_stat_ovr", 16'(bus.rdata), 16'h0004);
    cyc(1, 1, 1, 0); @(negedge clk);
    chk("lit_stat_clr", 16'(bus.rdata), 16'h0000);
    cyc(0, 0, 0, 0); tx_ready = 1'b1;
    cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_tx_load", 16'(tx_load), 16'd1);
    chk("lit_tx_data", 16'(tx_data), 16'h00A5);
    cyc(1, 1, 1, 0); @(negedge clk);
    chk("lit_tx_done", 16'({tx_load, bus.rdata}), 16'h0002);
    rda = 1'b1; rx_data = 8'h3C;
    cyc(1, 1, 0, 0); @(negedge clk);
    chk("lit_rx_data", 16'(bus.rdata), 16'h003C);
    chk("lit_rx_ack", 16'(rx_ack), 16'd1);
    rda = 1'b0; tx_ready = 1'b0;
    cyc(1, 0, 0, 8'h77); cyc(1, 0, 2, 8'h99); cyc(1, 0, 0, 8'h11); cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_lo_pend_busy", 16'(cfg_busy), 16'd1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_reload", {brg_wr_en, brg_in[14:0]}, {1'b1, 15'd325});
    cyc(1, 1, 1, 0); @(negedge clk);
    chk("lit_rst_status", 16'(bus.rdata), 16'h0002);
    cyc(1, 0, 3, 8'h03); cyc(0, 0, 0, 0); @(negedge clk);
    chk("lit_rst_lo_lost", brg_in, 16'h0345);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      rst        = ($urandom_range(0, 299) == 0);
      bus.iocs   = ($urandom_range(0, 2) != 0);
      bus.iorw   = $urandom_range(0, 1) == 1;
      bus.ioaddr = 2'($urandom_range(0, 3));
      bus.wdata  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tx_ready   = ($urandom_range(0, 3) == 0);
      rda        = $urandom_range(0, 1) == 1;
      rx_data    = 8'($urandom);
    end
    cyc(0, 0, 0, 0); rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
